// File: rtl/multi_mode_timer_if.sv
// multi_mode_timer_if: control and status bundle between a client FSM and multi_mode_timer.
interface multi_mode_timer_if #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
);
    logic [WIDTH-1:0] n_i;
    logic             start_i;
    logic             stop_i;
    logic             pause_i;
    logic             periodic_i;
    logic [PRE_W-1:0] prescale_i;
    logic [WIDTH-1:0] curr_time_q;
    logic             curr_end_q;
    logic             busy_q;
    modport master (
        output n_i, start_i, stop_i, pause_i, periodic_i, prescale_i,
        input  curr_time_q, curr_end_q, busy_q
    );
    modport slave (
        input  n_i, start_i, stop_i, pause_i, periodic_i, prescale_i,
        output curr_time_q, curr_end_q, busy_q
    );
endinterface

// File: rtl/multi_mode_timer.sv
// multi_mode_timer: one-shot/periodic delay timer with pause, stop and restart.
// Define MULTI_MODE_TIMER_PRESCALE_EN to build the clock-enable prescaler.
module multi_mode_timer #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input logic clk,
    input logic rst_n,
    multi_mode_timer_if.slave t
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] time_q, time_d, n_q, n_d;
    logic             end_q, end_d, busy_q, per_q, per_d;
    logic             tick, last, start_ok, adv;

    assign start_ok = t.start_i && !t.stop_i && (t.n_i != '0);
    assign adv      = !t.stop_i && !t.start_i && (state_q != IDLE) && !t.pause_i;
    assign last     = time_q == n_q - WIDTH'(1);

`ifdef MULTI_MODE_TIMER_PRESCALE_EN
    logic [PRE_W-1:0] pre_q, pcnt_q, pcnt_d;
    assign tick = pcnt_q == pre_q;
    // The prescaler only advances on cycles that would count, so pause freezes it too.
    assign pcnt_d = (t.stop_i || t.start_i) ? '0 :
                    adv ? (tick ? '0 : pcnt_q + PRE_W'(1)) : pcnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            pcnt_q <= '0;
        end else begin
            pre_q  <= start_ok ? t.prescale_i : pre_q;
            pcnt_q <= pcnt_d;
        end
    end
`else
    logic [PRE_W-1:0] unused_pre;
    assign unused_pre = t.prescale_i;
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        end_d   = 1'b0;
        n_d     = start_ok ? t.n_i : n_q;
        per_d   = start_ok ? t.periodic_i : per_q;
        if (t.stop_i) begin
            state_d = IDLE;
            time_d  = '0;
        end else if (t.start_i) begin
            state_d = start_ok ? RUN : IDLE;
            time_d  = '0;
            end_d   = !start_ok;
        end else if (state_q != IDLE && t.pause_i) begin
            state_d = PAUSE;
        end else if (state_q != IDLE) begin
            state_d = (tick && last && !per_q) ? IDLE : RUN;
            time_d  = !tick ? time_q : last ? '0 : time_q + WIDTH'(1);
            end_d   = tick && last;
        end else begin
            time_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            n_q     <= '0;
            per_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            end_q   <= end_d;
            busy_q  <= state_d != IDLE;
            n_q     <= n_d;
            per_q   <= per_d;
        end
    end

    assign t.curr_time_q = time_q;
    assign t.curr_end_q  = end_q;
    assign t.busy_q      = busy_q;
endmodule

// File: tb/tb_multi_mode_timer.sv
// tb_multi_mode_timer: directed checks of multi_mode_timer modes, pause, restart and reset.
module tb_multi_mode_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    multi_mode_timer_if #(.WIDTH(16), .PRE_W(8)) bus ();
    multi_mode_timer #(.WIDTH(16), .PRE_W(8)) dut (.clk(clk), .rst_n(rst_n), .t(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n, input bit per, input int pre);
        bus.n_i = 16'(n);
        bus.periodic_i = per;
        bus.prescale_i = 8'(pre);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.n_i = '0; bus.start_i = 0; bus.stop_i = 0; bus.pause_i = 0; bus.periodic_i = 0; bus.prescale_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.curr_time_q !== 16'd0) begin bad++; $display("FAIL rst_time got=%0d exp=0", bus.curr_time_q); end
        total++; if (bus.curr_end_q !== 1'b0) begin bad++; $display("FAIL rst_end got=%0b exp=0", bus.curr_end_q); end
        total++; if (bus.busy_q !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_one_shot();
        go(5, 0, 0);
        total++; if (bus.busy_q !== 1'b1 || bus.curr_time_q !== 16'd0) begin bad++; $display("FAIL os_start got busy=%0b time=%0d exp busy=1 time=0", bus.busy_q, bus.curr_time_q); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (bus.curr_time_q !== 16'(k < 5 ? k : 0)) begin bad++; $display("FAIL os_time e=%0d got=%0d exp=%0d", k, bus.curr_time_q, k < 5 ? k : 0); end
            total++; if (bus.curr_end_q !== (k == 5)) begin bad++; $display("FAIL os_end e=%0d got=%0b exp=%0b", k, bus.curr_end_q, k == 5); end
            total++; if (bus.busy_q !== (k < 5)) begin bad++; $display("FAIL os_busy e=%0d got=%0b exp=%0b", k, bus.busy_q, k < 5); end
        end
    endtask

    task automatic test_periodic_stop();
        go(3, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            bus.stop_i = (k == 7);
            tick();
            total++; if (bus.curr_time_q !== 16'(k < 7 ? k % 3 : 0)) begin bad++; $display("FAIL per_time e=%0d got=%0d exp=%0d", k, bus.curr_time_q, k < 7 ? k % 3 : 0); end
            total++; if (bus.curr_end_q !== (k < 7 && k % 3 == 0)) begin bad++; $display("FAIL per_end e=%0d got=%0b exp=%0b", k, bus.curr_end_q, k < 7 && k % 3 == 0); end
            total++; if (bus.busy_q !== (k < 7)) begin bad++; $display("FAIL per_busy e=%0d got=%0b exp=%0b", k, bus.busy_q, k < 7); end
        end
        bus.stop_i = 1'b0;
    endtask

    task automatic test_pause();
        int et[7] = '{1, 2, 2, 2, 3, 0, 0};
        go(4, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            bus.pause_i = (k == 3 || k == 4);
            if (k == 2) bus.n_i = 16'd9;
            tick();
            total++; if (bus.curr_time_q !== 16'(et[k-1])) begin bad++; $display("FAIL pause_time e=%0d got=%0d exp=%0d", k, bus.curr_time_q, et[k-1]); end
            total++; if (bus.curr_end_q !== (k == 6)) begin bad++; $display("FAIL pause_end e=%0d got=%0b exp=%0b", k, bus.curr_end_q, k == 6); end
            total++; if (bus.busy_q !== (k < 6)) begin bad++; $display("FAIL pause_busy e=%0d got=%0b exp=%0b", k, bus.busy_q, k < 6); end
        end
        bus.pause_i = 1'b0;
    endtask

    task automatic test_prescale();
`ifdef MULTI_MODE_TIMER_PRESCALE_EN
        int et[7] = '{0, 0, 1, 1, 1, 0, 0};
        int ee = 6;
`else
        int et[7] = '{1, 0, 0, 0, 0, 0, 0};
        int ee = 2;
`endif
        go(2, 0, 2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++; if (bus.curr_time_q !== 16'(et[k-1])) begin bad++; $display("FAIL pre_time e=%0d got=%0d exp=%0d", k, bus.curr_time_q, et[k-1]); end
            total++; if (bus.curr_end_q !== (k == ee)) begin bad++; $display("FAIL pre_end e=%0d got=%0b exp=%0b", k, bus.curr_end_q, k == ee); end
            total++; if (bus.busy_q !== (k < ee)) begin bad++; $display("FAIL pre_busy e=%0d got=%0b exp=%0b", k, bus.busy_q, k < ee); end
        end
    endtask

    task automatic test_zero_len();
        go(0, 1, 0);
        total++; if (bus.curr_end_q !== 1'b1) begin bad++; $display("FAIL zero_end got=%0b exp=1", bus.curr_end_q); end
        total++; if (bus.busy_q !== 1'b0 || bus.curr_time_q !== 16'd0) begin bad++; $display("FAIL zero_idle got busy=%0b time=%0d exp busy=0 time=0", bus.busy_q, bus.curr_time_q); end
        tick();
        total++; if (bus.curr_end_q !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%0b exp=0", bus.curr_end_q); end
    endtask

    task automatic test_restart();
        go(10, 0, 0);
        repeat (5) tick();
        total++; if (bus.curr_time_q !== 16'd5) begin bad++; $display("FAIL rs_pre got=%0d exp=5", bus.curr_time_q); end
        go(8, 0, 0);
        total++; if (bus.curr_time_q !== 16'd0 || bus.busy_q !== 1'b1) begin bad++; $display("FAIL rs_start got time=%0d busy=%0b exp time=0 busy=1", bus.curr_time_q, bus.busy_q); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++; if (bus.curr_time_q !== 16'(k < 8 ? k : 0)) begin bad++; $display("FAIL rs_time e=%0d got=%0d exp=%0d", k, bus.curr_time_q, k < 8 ? k : 0); end
            total++; if (bus.curr_end_q !== (k == 8)) begin bad++; $display("FAIL rs_end e=%0d got=%0b exp=%0b", k, bus.curr_end_q, k == 8); end
        end
    endtask

    task automatic test_start_stop();
        go(6, 1, 0);
        repeat (2) tick();
        bus.n_i = 16'd6; bus.start_i = 1'b1; bus.stop_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
        total++; if (bus.busy_q !== 1'b0 || bus.curr_time_q !== 16'd0 || bus.curr_end_q !== 1'b0) begin bad++; $display("FAIL ss_idle got busy=%0b time=%0d end=%0b exp 0 0 0", bus.busy_q, bus.curr_time_q, bus.curr_end_q); end
        tick();
        total++; if (bus.busy_q !== 1'b0 || bus.curr_time_q !== 16'd0) begin bad++; $display("FAIL ss_stay got busy=%0b time=%0d exp 0 0", bus.busy_q, bus.curr_time_q); end
    endtask

    task automatic test_async_reset();
        go(10, 1, 0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.busy_q !== 1'b0 || bus.curr_time_q !== 16'd0) begin bad++; $display("FAIL ar_run got busy=%0b time=%0d exp 0 0", bus.busy_q, bus.curr_time_q); end
        rst_n = 1'b1;
        go(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.curr_end_q !== 1'b0) begin bad++; $display("FAIL ar_end got=%0b exp=0", bus.curr_end_q); end
        rst_n = 1'b1;
        go(2, 0, 0);
        total++; if (bus.busy_q !== 1'b1) begin bad++; $display("FAIL ar_first got=%0b exp=1", bus.busy_q); end
        tick();
        total++; if (bus.curr_time_q !== 16'd1) begin bad++; $display("FAIL ar_time got=%0d exp=1", bus.curr_time_q); end
        tick();
        total++; if (bus.curr_end_q !== 1'b1 || bus.busy_q !== 1'b0) begin bad++; $display("FAIL ar_done got end=%0b busy=%0b exp 1 0", bus.curr_end_q, bus.busy_q); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic_stop();
        test_pause();
        test_prescale();
        test_zero_len();
        test_restart();
        test_start_stop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
